// File: rtl/multiport_regfile_pkg.sv
// rtl/multiport_regfile_pkg.sv - shared state enum and default parameters for the register file
package multiport_regfile_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_NREGS    = 32;
    localparam int DEF_NRD      = 2;
    localparam int DEF_NWR      = 1;
    localparam int DEF_BYPASS   = 1;
    localparam int DEF_INIT_VAL = 0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/multiport_regfile_scoreboard.sv
// rtl/multiport_regfile_scoreboard.sv - per-register pending bits with issue-over-writeback priority
module regfile_scoreboard
    import multiport_regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NWR   = DEF_NWR,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              iss_valid_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic [NWR-1:0]    w_en_i,
    input  logic [NWR*AW-1:0] w_addr_i,
    output logic [NREGS-1:0]  pend_o
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Clears are applied first so a same-cycle issue leaves the bit set.
    always_comb begin
        pend_d = pend_q;
        for (int w = 0; w < NWR; w++) begin
            if (w_en_i[w]) begin
                pend_d[w_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid_i) begin
            pend_d[iss_rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else if (en_i) begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - multiport register file with init sweep, bypass and pending scoreboard
module multiport_regfile
    import multiport_regfile_pkg::*;
#(
    parameter int XLEN               = DEF_XLEN,
    parameter int NREGS              = DEF_NREGS,
    parameter int NRD                = DEF_NRD,
    parameter int NWR                = DEF_NWR,
    parameter int BYPASS             = DEF_BYPASS,
    parameter logic [XLEN-1:0] INIT_VAL = XLEN'(DEF_INIT_VAL),
    localparam int AW                = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NRD-1:0]      rd_valid_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_pend_o,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic [NWR-1:0]      w_en_i,
    input  logic [NWR*AW-1:0]   w_addr_i,
    input  logic [NWR*XLEN-1:0] w_data_i,
    output logic                ready_o
);

    rf_state_e        state;
    logic [AW-1:0]    sweep_cnt;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] sb_pend;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ST_INIT;
            sweep_cnt <= AW'(1);
        end else if (state == ST_INIT) begin
            if (sweep_cnt == AW'(NREGS - 1)) begin
                state <= ST_RUN;
            end
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

    assign ready_o = (state == ST_RUN);

    // Contents have no reset; the sweep is the only initialisation path.
    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            regs[sweep_cnt] <= INIT_VAL;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (w_en_i[w] && (w_addr_i[w*AW +: AW] != '0)) begin
                    regs[w_addr_i[w*AW +: AW]] <= w_data_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (ready_o),
        .iss_valid_i (iss_valid_i),
        .iss_rd_i    (iss_rd_i),
        .w_en_i      (w_en_i),
        .w_addr_i    (w_addr_i),
        .pend_o      (sb_pend)
    );

    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            rpend;

    always_comb begin
        rd_data_o = '0;
        rd_pend_o = '0;
        ra        = '0;
        rdat      = '0;
        rpend     = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            ra    = rd_addr_i[p*AW +: AW];
            rdat  = '0;
            rpend = 1'b0;
            if (ready_o && rd_valid_i[p] && (ra != '0)) begin
                rdat  = regs[ra];
                rpend = sb_pend[ra];
                // Ascending scan lets the highest-index write port win the forward.
                if (BYPASS != 0) begin
                    for (int w = 0; w < NWR; w++) begin
                        if (w_en_i[w] && (w_addr_i[w*AW +: AW] == ra)) begin
                            rdat  = w_data_i[w*XLEN +: XLEN];
                            rpend = 1'b0;
                        end
                    end
                end
            end
            rd_data_o[p*XLEN +: XLEN] = rdat;
            rd_pend_o[p]              = rpend;
        end
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter XLEN, 32, data width in bits.
REQ-002 Parameter NREGS, 32, architectural register count (power of two, >=2); AW = log2(NREGS).
REQ-003 Parameter NRD, 2, read port count (1..4).
REQ-004 Parameter NWR, 1, write port count (1..2).
REQ-005 Parameter BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-006 Parameter INIT_VAL, 0, value loaded into every register except x0 by the init sweep.
REQ-007 clk_i  input  1  single clock, all state on rising edge.
REQ-008 rst_ni  input  1  asynchronous active-low reset.
REQ-009 rd_valid_i  input  NRD  per-port read enable.
REQ-010 rd_addr_i  input  NRD*AW  packed read addresses, port p at [p*AW +: AW].
REQ-011 rd_data_o  output  NRD*XLEN  packed read data.
REQ-012 rd_pend_o  output  NRD  read register has an outstanding write (scoreboard bit).
REQ-013 iss_valid_i  input  1  instruction issue, marks iss_rd_i pending.
REQ-014 iss_rd_i  input  AW  destination register of issued instruction.
REQ-015 w_en_i  input  NWR  per-port write enable (writeback).
REQ-016 w_addr_i  input  NWR*AW  packed write addresses.
REQ-017 w_data_i  input  NWR*XLEN  packed write data.
REQ-018 ready_o  output  1  init sweep complete; reads, writes and issues accepted.

Function
REQ-019 Register 0 reads 0 and is never written or marked pending.
REQ-020 Read is combinational: rd_data_o[p] = 0 when rd_valid_i[p]=0 or address 0; else register contents.
REQ-021 BYPASS=1: if w_en_i[w] and w_addr_i[w]==rd_addr_i[p]!=0 in the same cycle, rd_data_o[p] = w_data_i[w] and rd_pend_o[p]=0.
REQ-022 BYPASS=0: read returns the pre-edge value; new value visible the cycle after the write.
REQ-023 Write takes effect at the rising edge; latency 1 cycle.
REQ-024 Two write ports to the same non-zero address in one cycle: port NWR-1 (highest index) wins.
REQ-025 Scoreboard: one pending bit per register; set on iss_valid_i (iss_rd_i!=0); cleared on any enabled write to that register.
REQ-026 Issue and writeback to the same register in the same cycle: pending ends set (new producer wins).
REQ-027 rd_pend_o[p] = 0 when rd_valid_i[p]=0 or address 0.
REQ-028 FSM states INIT and RUN; reset enters INIT with sweep counter = 1.
REQ-029 INIT: one register per cycle written with INIT_VAL, counter increments; after register NREGS-1 go to RUN; duration NREGS-1 cycles.
REQ-030 INIT: ready_o=0, w_en_i and iss_valid_i ignored, rd_data_o all 0, rd_pend_o all 0.
REQ-031 RUN: ready_o=1; remains in RUN until reset.

Reset
REQ-032 rst_ni low asynchronously clears all pending bits, sets state INIT, counter 1, ready_o 0.
REQ-033 Register contents are not reset directly; the sweep initialises them.
REQ-034 Reset assertion mid-sweep or mid-operation restarts the sweep from register 1.

Structure
REQ-035 Shared package holds FSM state enum (INIT, RUN) and default parameter constants.
REQ-036 One sub-module, regfile_scoreboard, holds the pending bits and issue/clear priority; storage, bypass and sweep stay in the top.

Verification
REQ-039 Reset release, NREGS=32 -> ready_o rises after 31 cycles; read x5 -> INIT_VAL; read x0 -> 0.
REQ-040 RUN, write x3=0xDEADBEEF while reading x3 -> BYPASS=1 same-cycle 0xDEADBEEF; BYPASS=0 old value, then 0xDEADBEEF next cycle.
REQ-041 NWR=2, both ports write x7 (0x11, 0x22) -> x7 reads 0x22; write to x0 -> x0 still 0.
REQ-042 Issue x9 -> rd_pend_o for x9 is 1 next cycle; writeback x9 -> 0; issue+writeback x9 same cycle -> stays 1.
REQ-043 Assert rst_ni mid-sweep at counter 10 and during RUN with x4 pending -> pending cleared, ready_o 0, full 31-cycle sweep repeats.
REQ-044 During INIT drive w_en_i and iss_valid_i for x6 -> after sweep x6 = INIT_VAL, not pending.
